// File: rtl/commit_pkg.sv
// Shared types and limits for the commit-record pipeline.
package commit_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned ILEN      = 32;
    localparam int unsigned DEPTH_MAX = 8;

    // One commit record as it travels from fetch to the commit port.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pre_pc;
        logic [ILEN-1:0] instr;
    } commit_rec_t;

endpackage

// File: rtl/commit_stage.sv
// One pipeline slot: valid bit plus record, with hold and flush.
module commit_stage
    import commit_pkg::*;
#(
    parameter int unsigned W = $bits(commit_rec_t)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_hold,
    input  logic         i_flush,
    input  logic         i_up_valid,
    input  logic [W-1:0] i_up_rec,
    output logic         o_valid,
    output logic [W-1:0] o_rec
);

    logic         r_valid;
    logic [W-1:0] r_rec;

    // Valid bit: a held stage keeps its record unless flushed; otherwise
    // it takes whatever the upstream stage hands over.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
        end else if (i_hold) begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end
        end else begin
            r_valid <= i_up_valid;
        end
    end

    // Record payload follows the valid bit's advance; stale data is harmless.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rec <= '0;
        end else if (!i_hold) begin
            r_rec <= i_up_rec;
        end
    end

    assign o_valid = r_valid;
    assign o_rec   = r_rec;

endmodule

// File: rtl/commit_pipe.sv
// Commit-record pipeline with per-stage valid, backward stall, per-stage
// flush, retire counter and occupancy. DEPTH is expected in 2..DEPTH_MAX.
module commit_pipe #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [XLEN-1:0]              in_pre_pc,
    input  logic [ILEN-1:0]              in_instr,
    output logic                         in_ready,
    input  logic [DEPTH-1:0]             stall_vec,
    input  logic [DEPTH-1:0]             flush_vec,
    output logic                         commit,
    output logic [XLEN-1:0]              commit_pc,
    output logic [XLEN-1:0]              commit_pre_pc,
    output logic [ILEN-1:0]              commit_instr,
    output logic [63:0]                  retire_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned REC_W = 2 * XLEN + ILEN;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] w_hold;
    logic [DEPTH-1:0] w_up_valid;
    logic [DEPTH-1:0] w_valid;
    logic [REC_W-1:0] w_up_rec [DEPTH];
    logic [REC_W-1:0] w_rec    [DEPTH];
    logic             w_commit;
    logic [OCC_W-1:0] w_occ;
    logic [63:0]      r_retire_cnt;

    // Hold is the OR of this stage's stall and every stall downstream of it.
    always_comb begin
        w_hold            = '0;
        w_hold[DEPTH-1]   = stall_vec[DEPTH-1];
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_hold[DEPTH-1-k] = stall_vec[DEPTH-1-k] | w_hold[DEPTH-k];
        end
    end

    // Upstream hand-off: a bubble is passed on when the source stage is
    // held or flushed; stage 0 loads straight from fetch.
    always_comb begin
        w_up_valid    = '0;
        w_up_valid[0] = in_valid;
        w_up_rec[0]   = {in_pc, in_pre_pc, in_instr};
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_up_valid[k] = w_valid[k-1] & ~flush_vec[k-1] & ~w_hold[k-1];
            w_up_rec[k]   = w_rec[k-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        commit_stage #(
            .W (REC_W)
        ) u_stage (
            .i_clk      (clk),
            .i_rst_n    (rst),
            .i_hold     (w_hold[g]),
            .i_flush    (flush_vec[g]),
            .i_up_valid (w_up_valid[g]),
            .i_up_rec   (w_up_rec[g]),
            .o_valid    (w_valid[g]),
            .o_rec      (w_rec[g])
        );
    end

    assign w_commit = w_valid[DEPTH-1] & ~stall_vec[DEPTH-1] & ~flush_vec[DEPTH-1];

    // Retired-record counter, free-running modulo 2^64.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_cnt <= '0;
        end else if (w_commit) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    // Occupancy is the popcount of the registered valid bits.
    always_comb begin
        w_occ = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_occ = w_occ + OCC_W'(w_valid[k]);
        end
    end

    assign in_ready = ~w_hold[0];
    assign commit   = w_commit;
    assign {commit_pc, commit_pre_pc, commit_instr} = w_rec[DEPTH-1];
    assign retire_cnt = r_retire_cnt;
    assign occupancy  = w_occ;

endmodule

// File: tb/tb_commit_pipe.sv
// Directed self-checking bench for commit_pipe (DEPTH=4 and DEPTH=2).
module tb_commit_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid;
    logic [63:0] in_pc, in_pre_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic [3:0]  stall_vec, flush_vec;
    logic        commit;
    logic [63:0] commit_pc, commit_pre_pc;
    logic [31:0] commit_instr;
    logic [63:0] retire_cnt;
    logic [2:0]  occupancy;

    logic        in_valid2;
    logic [63:0] in_pc2, in_pre_pc2;
    logic [31:0] in_instr2;
    logic        in_ready2;
    logic [1:0]  stall_vec2, flush_vec2;
    logic        commit2;
    logic [63:0] commit_pc2, commit_pre_pc2;
    logic [31:0] commit_instr2;
    logic [63:0] retire_cnt2;
    logic [1:0]  occupancy2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    commit_pipe #(.DEPTH(4), .XLEN(64), .ILEN(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
        .in_pre_pc(in_pre_pc), .in_instr(in_instr), .in_ready(in_ready),
        .stall_vec(stall_vec), .flush_vec(flush_vec), .commit(commit),
        .commit_pc(commit_pc), .commit_pre_pc(commit_pre_pc),
        .commit_instr(commit_instr), .retire_cnt(retire_cnt), .occupancy(occupancy)
    );

    commit_pipe #(.DEPTH(2), .XLEN(64), .ILEN(32)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_pc(in_pc2),
        .in_pre_pc(in_pre_pc2), .in_instr(in_instr2), .in_ready(in_ready2),
        .stall_vec(stall_vec2), .flush_vec(flush_vec2), .commit(commit2),
        .commit_pc(commit_pc2), .commit_pre_pc(commit_pre_pc2),
        .commit_instr(commit_instr2), .retire_cnt(retire_cnt2), .occupancy(occupancy2)
    );

    function automatic logic [63:0] f_pc(int idx);
        return 64'h1000 + 64'(idx) * 64'd4;
    endfunction

    function automatic logic [63:0] f_pre(int idx);
        return f_pc(idx) ^ 64'hA5A5_0000_0000_0000;
    endfunction

    function automatic logic [31:0] f_instr(int idx);
        return 32'h00A0_0013 + 32'(idx);
    endfunction

    task automatic drive(input int v, input int idx, input logic [3:0] st, input logic [3:0] fl);
        in_valid  = v[0];
        in_pc     = f_pc(idx);
        in_pre_pc = f_pre(idx);
        in_instr  = f_instr(idx);
        stall_vec = st;
        flush_vec = fl;
    endtask

    task automatic drive2(input int v, input int idx);
        in_valid2   = v[0];
        in_pc2      = f_pc(idx);
        in_pre_pc2  = f_pre(idx);
        in_instr2   = f_instr(idx);
        stall_vec2  = 2'b00;
        flush_vec2  = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        drive(0, 0, 4'b0, 4'b0);
        drive2(0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (commit !== 1'b0) begin n_errors++; $display("FAIL reset_commit got=%b exp=0", commit); end
        n_checks++; if ({commit_pc, commit_pre_pc, commit_instr} !== 160'd0) begin n_errors++; $display("FAIL reset_rec got=%h/%h/%h exp=0", commit_pc, commit_pre_pc, commit_instr); end
        n_checks++; if (occupancy !== 3'd0) begin n_errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        n_checks++; if (retire_cnt !== 64'd0) begin n_errors++; $display("FAIL reset_retire got=%0d exp=0", retire_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        n_checks++; if (occupancy2 !== 2'd0) begin n_errors++; $display("FAIL reset_occ2 got=%0d exp=0", occupancy2); end
        drive(0, 0, 4'b0100, 4'b0); #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL ready_stall2 got=%b exp=0", in_ready); end
        drive(0, 0, 4'b1000, 4'b0); #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL ready_stall3 got=%b exp=0", in_ready); end
        drive(0, 0, 4'b0000, 4'b1111); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL ready_flush got=%b exp=1", in_ready); end
        drive(0, 0, 4'b0, 4'b0);
        tick();
    endtask

    task automatic test_free_run();
        int iv[8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        int ec[8] = '{-1, -1, -1, -1, 0, 1, 2, -1};
        int eo[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            drive(iv[c], c, 4'b0, 4'b0); #1;
            n_checks++; if (commit !== (ec[c] >= 0)) begin n_errors++; $display("FAIL free_commit c=%0d got=%b exp=%b", c, commit, ec[c] >= 0); end
            if (ec[c] >= 0) begin
                n_checks++;
                if (commit_pc !== f_pc(ec[c]) || commit_pre_pc !== f_pre(ec[c]) || commit_instr !== f_instr(ec[c])) begin
                    n_errors++; $display("FAIL free_rec c=%0d got=%h/%h exp=%h/%h", c, commit_pc, commit_instr, f_pc(ec[c]), f_instr(ec[c]));
                end
            end
            n_checks++; if (occupancy !== 3'(eo[c])) begin n_errors++; $display("FAIL free_occ c=%0d got=%0d exp=%0d", c, occupancy, eo[c]); end
            tick();
        end
        n_checks++; if (retire_cnt !== 64'd3) begin n_errors++; $display("FAIL free_retire got=%0d exp=3", retire_cnt); end
    endtask

    task automatic test_stall();
        int         iv[12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        int         ix[12] = '{0, 1, 2, 3, 4, 4, 4, 0, 0, 0, 0, 0};
        logic [3:0] st[12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        int         ec[12] = '{-1, -1, -1, -1, 0, -1, -1, 1, 2, 3, 4, -1};
        int         er[12] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        int         eo[12] = '{0, 1, 2, 3, 4, 3, 3, 4, 3, 2, 1, 0};
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            drive(iv[c], ix[c], st[c], 4'b0); #1;
            n_checks++; if (in_ready !== er[c][0]) begin n_errors++; $display("FAIL stall_ready c=%0d got=%b exp=%0d", c, in_ready, er[c]); end
            n_checks++; if (commit !== (ec[c] >= 0)) begin n_errors++; $display("FAIL stall_commit c=%0d got=%b exp=%b", c, commit, ec[c] >= 0); end
            if (ec[c] >= 0) begin
                n_checks++;
                if (commit_pc !== f_pc(ec[c]) || commit_pre_pc !== f_pre(ec[c]) || commit_instr !== f_instr(ec[c])) begin
                    n_errors++; $display("FAIL stall_rec c=%0d got=%h exp=%h", c, commit_pc, f_pc(ec[c]));
                end
            end
            n_checks++; if (occupancy !== 3'(eo[c])) begin n_errors++; $display("FAIL stall_occ c=%0d got=%0d exp=%0d", c, occupancy, eo[c]); end
            tick();
        end
        n_checks++; if (retire_cnt !== 64'd5) begin n_errors++; $display("FAIL stall_retire got=%0d exp=5", retire_cnt); end
    endtask

    task automatic test_flush_stall();
        int         iv[11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        int         ix[11] = '{0, 1, 2, 3, 4, 4, 0, 0, 0, 0, 0};
        logic [3:0] sf[11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        int         ec[11] = '{-1, -1, -1, -1, 0, 1, -1, -1, 3, 4, -1};
        int         er[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        int         eo[11] = '{0, 1, 2, 3, 4, 2, 2, 2, 2, 1, 0};
        apply_reset();
        for (int c = 0; c < 11; c++) begin
            drive(iv[c], ix[c], sf[c], sf[c]); #1;
            n_checks++; if (in_ready !== er[c][0]) begin n_errors++; $display("FAIL fstall_ready c=%0d got=%b exp=%0d", c, in_ready, er[c]); end
            n_checks++; if (commit !== (ec[c] >= 0)) begin n_errors++; $display("FAIL fstall_commit c=%0d got=%b exp=%b", c, commit, ec[c] >= 0); end
            if (ec[c] >= 0) begin
                n_checks++;
                if (commit_pc !== f_pc(ec[c]) || commit_instr !== f_instr(ec[c])) begin
                    n_errors++; $display("FAIL fstall_rec c=%0d got=%h exp=%h", c, commit_pc, f_pc(ec[c]));
                end
            end
            n_checks++; if (occupancy !== 3'(eo[c])) begin n_errors++; $display("FAIL fstall_occ c=%0d got=%0d exp=%0d", c, occupancy, eo[c]); end
            tick();
        end
        n_checks++; if (retire_cnt !== 64'd4) begin n_errors++; $display("FAIL fstall_retire got=%0d exp=4", retire_cnt); end
    endtask

    task automatic test_flush_all();
        int         iv[10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        logic [3:0] fl[10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        int         ec[10] = '{-1, -1, -1, -1, -1, -1, -1, -1, 4, -1};
        int         eo[10] = '{0, 1, 2, 3, 4, 1, 1, 1, 1, 0};
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            drive(iv[c], c, 4'b0, fl[c]); #1;
            n_checks++; if (commit !== (ec[c] >= 0)) begin n_errors++; $display("FAIL fall_commit c=%0d got=%b exp=%b", c, commit, ec[c] >= 0); end
            if (ec[c] >= 0) begin
                n_checks++; if (commit_pc !== f_pc(ec[c])) begin n_errors++; $display("FAIL fall_rec c=%0d got=%h exp=%h", c, commit_pc, f_pc(ec[c])); end
            end
            n_checks++; if (occupancy !== 3'(eo[c])) begin n_errors++; $display("FAIL fall_occ c=%0d got=%0d exp=%0d", c, occupancy, eo[c]); end
            tick();
        end
        n_checks++; if (retire_cnt !== 64'd1) begin n_errors++; $display("FAIL fall_retire got=%0d exp=1", retire_cnt); end
    endtask

    task automatic test_last_stall();
        int         iv[13] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        int         ix[13] = '{0, 1, 2, 3, 4, 4, 4, 4, 0, 0, 0, 0, 0};
        logic [3:0] st[13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        int         ec[13] = '{-1, -1, -1, -1, -1, -1, -1, 0, 1, 2, 3, 4, -1};
        int         er[13] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        int         eo[13] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0};
        apply_reset();
        for (int c = 0; c < 13; c++) begin
            drive(iv[c], ix[c], st[c], 4'b0); #1;
            n_checks++; if (in_ready !== er[c][0]) begin n_errors++; $display("FAIL lstall_ready c=%0d got=%b exp=%0d", c, in_ready, er[c]); end
            n_checks++; if (commit !== (ec[c] >= 0)) begin n_errors++; $display("FAIL lstall_commit c=%0d got=%b exp=%b", c, commit, ec[c] >= 0); end
            if (ec[c] >= 0) begin
                n_checks++; if (commit_pc !== f_pc(ec[c])) begin n_errors++; $display("FAIL lstall_rec c=%0d got=%h exp=%h", c, commit_pc, f_pc(ec[c])); end
            end
            n_checks++; if (occupancy !== 3'(eo[c])) begin n_errors++; $display("FAIL lstall_occ c=%0d got=%0d exp=%0d", c, occupancy, eo[c]); end
            tick();
        end
        n_checks++; if (retire_cnt !== 64'd5) begin n_errors++; $display("FAIL lstall_retire got=%0d exp=5", retire_cnt); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1, c, 4'b0, 4'b0);
            tick();
        end
        drive(1, 10, 4'b0, 4'b0); #1;
        n_checks++; if (retire_cnt !== 64'd2) begin n_errors++; $display("FAIL mid_pre_retire got=%0d exp=2", retire_cnt); end
        n_checks++; if (commit !== 1'b1 || commit_pc !== f_pc(2)) begin n_errors++; $display("FAIL mid_pre_commit got=%b/%h exp=1/%h", commit, commit_pc, f_pc(2)); end
        rst = 1'b0; #1;
        n_checks++; if (commit !== 1'b0) begin n_errors++; $display("FAIL mid_commit got=%b exp=0", commit); end
        n_checks++; if (occupancy !== 3'd0) begin n_errors++; $display("FAIL mid_occ got=%0d exp=0", occupancy); end
        n_checks++; if (retire_cnt !== 64'd0) begin n_errors++; $display("FAIL mid_retire got=%0d exp=0", retire_cnt); end
        n_checks++; if (commit_pc !== 64'd0) begin n_errors++; $display("FAIL mid_pc got=%h exp=0", commit_pc); end
        #1 rst = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 4'b0, 4'b0); #1;
            n_checks++; if (commit !== (c == 3)) begin n_errors++; $display("FAIL mid_after_commit c=%0d got=%b exp=%b", c, commit, c == 3); end
            if (c == 3) begin
                n_checks++; if (commit_pc !== f_pc(10) || commit_instr !== f_instr(10)) begin n_errors++; $display("FAIL mid_after_rec got=%h exp=%h", commit_pc, f_pc(10)); end
            end
            tick();
        end
        n_checks++; if (retire_cnt !== 64'd1) begin n_errors++; $display("FAIL mid_after_retire got=%0d exp=1", retire_cnt); end
    endtask

    task automatic test_depth2();
        int iv[6] = '{1, 1, 1, 0, 0, 0};
        int ec[6] = '{-1, -1, 0, 1, 2, -1};
        int eo[6] = '{0, 1, 2, 2, 1, 0};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            drive2(iv[c], c); #1;
            n_checks++; if (in_ready2 !== 1'b1) begin n_errors++; $display("FAIL d2_ready c=%0d got=%b exp=1", c, in_ready2); end
            n_checks++; if (commit2 !== (ec[c] >= 0)) begin n_errors++; $display("FAIL d2_commit c=%0d got=%b exp=%b", c, commit2, ec[c] >= 0); end
            if (ec[c] >= 0) begin
                n_checks++;
                if (commit_pc2 !== f_pc(ec[c]) || commit_pre_pc2 !== f_pre(ec[c]) || commit_instr2 !== f_instr(ec[c])) begin
                    n_errors++; $display("FAIL d2_rec c=%0d got=%h exp=%h", c, commit_pc2, f_pc(ec[c]));
                end
            end
            n_checks++; if (occupancy2 !== 2'(eo[c])) begin n_errors++; $display("FAIL d2_occ c=%0d got=%0d exp=%0d", c, occupancy2, eo[c]); end
            tick();
        end
        n_checks++; if (retire_cnt2 !== 64'd3) begin n_errors++; $display("FAIL d2_retire got=%0d exp=3", retire_cnt2); end
    endtask

    initial begin
        drive(0, 0, 4'b0, 4'b0);
        drive2(0, 0);
        test_reset();
        test_free_run();
        test_stall();
        test_flush_stall();
        test_flush_all();
        test_last_stall();
        test_reset_midstream();
        test_depth2();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
